// File: rtl/div_pkg.sv
// div_pkg: shared width default, FSM state type and step-counter width for the sequential divider.
package div_pkg;
  localparam int DIV_W = 16;
  localparam int CNT_W = $clog2(DIV_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift, trial subtract, restore or commit).
module div_step #(
  parameter int WIDTH = div_pkg::DIV_W
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] sh;
  logic [WIDTH:0] trial;
  logic           ge;
  // rem[WIDTH] shifts out of the window; if set the shifted value already exceeds any divisor
  assign sh       = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign trial    = sh - {1'b0, divisor};
  assign ge       = rem[WIDTH] | (sh >= {1'b0, divisor});
  assign rem_next = ge ? trial : sh;
  assign q_next   = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_div16.sv
// seq_div16: iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_div16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state, state_nx;
  logic [WIDTH:0]   rem_w, rem_nx;
  logic [WIDTH-1:0] q_w, q_nx, dvs;
  logic [CW-1:0]    cnt;
  logic             accept, zero, last;
  assign accept = start && state != RUN;
  assign zero   = divisor == '0;
  assign last   = cnt == CW'(1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_w),
    .q        (q_w),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_next   (q_nx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = accept ? (zero ? DONE : RUN) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dvs         <= '0;
      q_w         <= '0;
      rem_w       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvs         <= divisor;
      q_w         <= dividend;
      rem_w       <= '0;
      cnt         <= CW'(WIDTH);
      div_by_zero <= zero;
      if (zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      rem_w <= rem_nx;
      q_w   <= q_nx;
      cnt   <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_nx;
        remainder <= rem_nx[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16: directed and randomized checks of seq_div16 against plain / and % arithmetic.
module tb_seq_div16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int          n_assert = 0;
  int          n_fail = 0;

  seq_div16 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // n = edges after the accepting edge until done is seen; nb = cycles with busy high before that
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n, nb;
    logic [15:0] eq, er;
    eq = (b == 0) ? 16'hFFFF : a / b;
    er = (b == 0) ? a : a % b;
    go(a, b);
    wait_done(n, nb);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(n), (b == 0) ? 32'd0 : 32'd16);
    check({tag, " busy_cycles"}, 32'(nb), (b == 0) ? 32'd0 : 32'd16);
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " dbz"}, 32'(div_by_zero), 32'(b == 0));
  endtask

  initial begin
    int n, nb, cnt;
    logic [15:0] a, b;
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    run_div("100/7", 16'd100, 16'd7);
    tick();
    check("done one-cycle", 32'(done), 32'd0);
    check("result held", 32'(quotient), 32'd14);
    run_div("ffff/1", 16'hFFFF, 16'd1);
    run_div("3/10", 16'd3, 16'd10);
    run_div("5/0", 16'd5, 16'd0);

    // start during busy is ignored
    go(16'd1000, 16'd3);
    repeat (4) tick();
    start = 1'b1; dividend = 16'd9; divisor = 16'd9;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check("ignored done", 32'(done), 32'd1);
    check("ignored latency", 32'(n), 32'd11);
    check("ignored quotient", 32'(quotient), 32'd333);
    check("ignored remainder", 32'(remainder), 32'd1);
    tick();
    check("ignored no 2nd run", 32'(busy), 32'd0);

    // asynchronous reset mid-operation
    go(16'd50000, 16'd123);
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (25) begin
      tick();
      if (done || busy) cnt++;
    end
    check("abort no done", 32'(cnt), 32'd0);
    run_div("49/7", 16'd49, 16'd7);

    // back-to-back: new start in the DONE cycle
    tick();
    go(16'd200, 16'd9);
    wait_done(n, nb);
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first quotient", 32'(quotient), 32'd22);
    check("b2b first remainder", 32'(remainder), 32'd2);
    go(16'd7, 16'd2);
    check("b2b restart busy", 32'(busy), 32'd1);
    wait_done(n, nb);
    check("b2b second latency", 32'(n), 32'd16);
    check("b2b second quotient", 32'(quotient), 32'd3);
    check("b2b second remainder", 32'(remainder), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        default: b = 16'($urandom);
      endcase
      run_div("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
